// File: rtl/io_tile_config_loader_pkg.sv
// Shared state encoding and sizing for the IO tile configuration loader.
package io_tile_config_loader_pkg;

  localparam int DEFAULT_CONFIG_WIDTH = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } loader_state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/io_tile_config_loader_if.sv
// Serial configuration stream in, committed word and daisy-chain stream out.
interface io_tile_config_loader_if #(
  parameter int CONFIG_WIDTH = io_tile_config_loader_pkg::DEFAULT_CONFIG_WIDTH
);

  logic                    cfg_start;
  logic                    cfg_data;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    cfg_done;
  logic                    chain_data;
  logic                    chain_valid;

  modport master (
    output cfg_start, cfg_data, cfg_valid,
    input  cfg_ready, config_out, cfg_done, chain_data, chain_valid
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid,
    output cfg_ready, config_out, cfg_done, chain_data, chain_valid
  );

endinterface

// File: rtl/io_tile_config_loader_counter.sv
// Bit counter for one configuration word; wraps at CONFIG_WIDTH-1 so it never exceeds it.
module config_bit_counter
  import io_tile_config_loader_pkg::*;
#(
  parameter  int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
  localparam int CNT_W        = cnt_width(CONFIG_WIDTH)
) (
  input  logic clock,
  input  logic nreset,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONFIG_WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == LAST);

endmodule

// File: rtl/io_tile_config_loader.sv
// Shifts a serial config word in, commits it atomically to the IO tile, and
// forwards displaced bits to the next tile in the daisy chain.
//
//   state     | meaning
//   ST_IDLE   | waiting for cfg_start, stream ignored
//   ST_SHIFT  | accepting bits, cfg_ready high
//   ST_COMMIT | copy shift register to config_out, pulse cfg_done
module io_tile_config_loader
  import io_tile_config_loader_pkg::*;
#(
  parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH
) (
  input  logic                   clock,
  input  logic                   nreset,
  io_tile_config_loader_if.slave cfg_if
);

  loader_state_e           state_q, state_d;
  logic [CONFIG_WIDTH-1:0] sr_q, sr_d;
  logic [CONFIG_WIDTH-1:0] cfg_out_q, cfg_out_d;
  logic                    done_q, done_d;
  logic                    chain_data_q, chain_data_d;
  logic                    chain_valid_q, chain_valid_d;
  logic                    cnt_clear, cnt_inc, cnt_last;
  logic                    accept;

  config_bit_counter #(.CONFIG_WIDTH(CONFIG_WIDTH)) u_bit_counter (
    .clock   (clock),
    .nreset  (nreset),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .last_o  (cnt_last)
  );

  assign accept = cfg_if.cfg_valid && (state_q == ST_SHIFT);

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    cfg_out_d     = cfg_out_q;
    done_d        = 1'b0;
    chain_data_d  = chain_data_q;
    chain_valid_d = 1'b0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_if.cfg_start) begin
          state_d   = ST_SHIFT;
          cnt_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A restart wins over a bit arriving in the same cycle and wipes the partial word.
        if (cfg_if.cfg_start) begin
          cnt_clear = 1'b1;
          sr_d      = '0;
        end else if (accept) begin
          sr_d          = {cfg_if.cfg_data, sr_q[CONFIG_WIDTH-1:1]};
          chain_data_d  = sr_q[0];
          chain_valid_d = 1'b1;
          cnt_inc       = 1'b1;
          if (cnt_last) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        cfg_out_d = sr_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      cfg_out_q     <= '0;
      done_q        <= 1'b0;
      chain_data_q  <= 1'b0;
      chain_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cfg_out_q     <= cfg_out_d;
      done_q        <= done_d;
      chain_data_q  <= chain_data_d;
      chain_valid_q <= chain_valid_d;
    end
  end

  assign cfg_if.cfg_ready   = (state_q == ST_SHIFT);
  assign cfg_if.config_out  = cfg_out_q;
  assign cfg_if.cfg_done    = done_q;
  assign cfg_if.chain_data  = chain_data_q;
  assign cfg_if.chain_valid = chain_valid_q;

endmodule

// File: tb/tb_io_tile_config_loader.sv
// Self-checking bench for io_tile_config_loader: directed load table, corner sequences, random traffic.
module tb_io_tile_config_loader;

  localparam int W = 24;

  logic clock;
  logic nreset;

  io_tile_config_loader_if #(.CONFIG_WIDTH(W)) cfg_if ();

  io_tile_config_loader #(.CONFIG_WIDTH(W)) dut (
    .clock  (clock),
    .nreset (nreset),
    .cfg_if (cfg_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 loading, 2 commit pending.
  int          m_phase = 0;
  int          m_bits  = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_cfg  = '0;
  logic        m_done  = 1'b0;
  logic        m_cd    = 1'b0;
  logic        m_cv    = 1'b0;

  int g_base, g_done_at, g_chain_cnt, g_chain_ones;

  typedef struct {
    logic [W-1:0] word;
    int           gap;
    int           exp_done;
  } load_vec_t;

  load_vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit rn, input bit st, input bit v, input bit d);
    if (!rn) begin
      m_phase = 0; m_bits = 0; m_word = '0; m_cfg = '0;
      m_done = 1'b0; m_cd = 1'b0; m_cv = 1'b0;
    end else begin
      m_done = 1'b0;
      m_cv   = 1'b0;
      if (m_phase == 0) begin
        if (st) begin m_phase = 1; m_bits = 0; end
      end else if (m_phase == 1) begin
        if (st) begin
          m_bits = 0;
          m_word = '0;
        end else if (v) begin
          m_cd   = m_word[0];
          m_cv   = 1'b1;
          m_word = (m_word >> 1) | (W'(d) << (W - 1));
          m_bits = m_bits + 1;
          if (m_bits == W) m_phase = 2;
        end
      end else begin
        m_cfg   = m_word;
        m_done  = 1'b1;
        m_phase = 0;
      end
    end
  endtask

  task automatic tick(input bit rn, input bit st, input bit v, input bit d);
    nreset           = rn;
    cfg_if.cfg_start = st;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_data  = d;
    @(posedge clock);
    model_step(rn, st, v, d);
    #1;
    cyc++;
    chk("ready",       32'(cfg_if.cfg_ready),   32'(m_phase == 1));
    chk("done",        32'(cfg_if.cfg_done),    32'(m_done));
    chk("chain_valid", 32'(cfg_if.chain_valid), 32'(m_cv));
    chk("chain_data",  32'(cfg_if.chain_data),  32'(m_cd));
    chk("config_out",  32'(cfg_if.config_out),  32'(m_cfg));
    if (cfg_if.cfg_done === 1'b1 && g_done_at < 0) g_done_at = cyc - g_base;
    if (cfg_if.chain_valid === 1'b1) begin
      g_chain_cnt++;
      if (cfg_if.chain_data === 1'b1) g_chain_ones++;
    end
  endtask

  task automatic run_load(input logic [W-1:0] word, input int gap);
    logic [W-1:0] prev;
    prev         = m_cfg;
    g_base       = cyc;
    g_done_at    = -1;
    g_chain_cnt  = 0;
    g_chain_ones = 0;
    tick(1, 1, 0, 0);
    for (int i = 0; i < W; i++) begin
      tick(1, 0, 1, word[i]);
      if (i < W - 1)
        for (int g = 0; g < gap; g++) tick(1, 0, 0, 1'($urandom_range(0, 1)));
    end
    chk("hold_before_commit", 32'(cfg_if.config_out), 32'(prev));
    for (int k = 0; k < 6 && g_done_at < 0; k++) tick(1, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{word: 24'hA5C3F1, gap: 0, exp_done: 26};
    vecs[1] = '{word: 24'hA5C3F1, gap: 1, exp_done: 49};
    vecs[2] = '{word: 24'h123456, gap: 2, exp_done: 72};
    vecs[3] = '{word: 24'h0F0F0F, gap: 0, exp_done: 26};
    vecs[4] = '{word: 24'h800001, gap: 1, exp_done: 49};

    g_done_at = -1;
    tick(0, 0, 0, 0);
    chk("reset_config", 32'(cfg_if.config_out), 32'h0);
    chk("reset_ready",  32'(cfg_if.cfg_ready),  32'h0);
    tick(0, 1, 1, 1);
    tick(1, 0, 1, 1);
    chk("idle_ignores_valid", 32'(cfg_if.chain_valid), 32'h0);

    for (int v = 0; v < 5; v++) begin
      run_load(vecs[v].word, vecs[v].gap);
      chk($sformatf("vec%0d_done_cycle", v), 32'(g_done_at), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_config", v), 32'(cfg_if.config_out), 32'(vecs[v].word));
      chk($sformatf("vec%0d_chain_cnt", v), 32'(g_chain_cnt), 32'(W));
    end

    // All-ones word then all-zeros: the second load pushes the ones down the chain.
    run_load(24'hFFFFFF, 0);
    chk("ones_config", 32'(cfg_if.config_out), 32'hFFFFFF);
    run_load(24'h000000, 0);
    chk("zeros_chain_cnt",  32'(g_chain_cnt),  32'd24);
    chk("zeros_chain_ones", 32'(g_chain_ones), 32'd24);
    chk("zeros_config",     32'(cfg_if.config_out), 32'h0);

    // Restart after 10 bits leaves nothing of the aborted word.
    run_load(24'hFFFFFF, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 1, 1'($urandom_range(0, 1)));
    run_load(24'h123456, 0);
    chk("restart_config",     32'(cfg_if.config_out), 32'h123456);
    chk("restart_done_cycle", 32'(g_done_at), 32'd26);
    chk("restart_chain_ones", 32'(g_chain_ones), 32'd0);

    // Reset mid-load after 12 bits.
    tick(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) tick(1, 0, 1, 1'((24'hABCDEF >> i) & 1));
    tick(0, 0, 1, 1);
    chk("midreset_config", 32'(cfg_if.config_out), 32'h0);
    chk("midreset_ready",  32'(cfg_if.cfg_ready),  32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 1'($urandom_range(0, 1)));
      chk("post_reset_ready", 32'(cfg_if.cfg_ready),   32'h0);
      chk("post_reset_chain", 32'(cfg_if.chain_valid), 32'h0);
    end

    // Start during COMMIT is ignored.
    g_base = cyc; g_done_at = -1;
    tick(1, 1, 0, 0);
    for (int i = 0; i < W; i++) tick(1, 0, 1, 1'((24'h5A5A5A >> i) & 1));
    tick(1, 1, 0, 0);
    chk("commit_start_done",   32'(cfg_if.cfg_done),   32'h1);
    chk("commit_start_ready",  32'(cfg_if.cfg_ready),  32'h0);
    chk("commit_start_config", 32'(cfg_if.config_out), 32'h5A5A5A);
    tick(1, 0, 1, 1);
    chk("commit_start_idle", 32'(cfg_if.cfg_ready), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
